// File: rtl/herv_axi_pkg.sv
// Shared constants, FSM state types and request checks for the AXI memory responder.
package herv_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_64B    = 3'd6;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    // Only full-width INCR bursts are served; anything else completes with SLVERR.
    function automatic logic bad_req(input logic [2:0] size, input logic [1:0] burst);
        return (size != SIZE_64B) || (burst != BURST_INCR);
    endfunction

endpackage

// File: rtl/axi_mem_bank.sv
// Simple dual-port byte-enabled RAM with a registered, read-enabled, read-first output.
module axi_mem_bank #(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    re,
    input  logic [ADDR_WIDTH-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
    localparam int unsigned NUM_BYTE = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    // Array is never reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < NUM_BYTE; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 subordinate backed by on-chip RAM; one write and one read burst in flight,
// each channel pair driven by its own FSM.
module axi_mem_responder
    import herv_axi_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 512,
    parameter int unsigned AXI_ID_WIDTH   = 12,
    parameter int unsigned MEM_ADDR_WIDTH = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [AXI_ID_WIDTH-1:0]     s_axi_awid,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]                  s_axi_awlen,
    input  logic [2:0]                  s_axi_awsize,
    input  logic [1:0]                  s_axi_awburst,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                        s_axi_wlast,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    output logic [AXI_ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    input  logic [AXI_ID_WIDTH-1:0]     s_axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]                  s_axi_arlen,
    input  logic [2:0]                  s_axi_arsize,
    input  logic [1:0]                  s_axi_arburst,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    output logic [AXI_ID_WIDTH-1:0]     s_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rlast,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready
);

    localparam int unsigned BEAT_LSB = $clog2(AXI_DATA_WIDTH / 8);
    localparam int unsigned IDX_W    = MEM_ADDR_WIDTH;

    w_state_e              w_state_q, w_state_d;
    logic [AXI_ID_WIDTH-1:0] w_id_q, w_id_d;
    logic [IDX_W-1:0]      w_idx_q, w_idx_d;
    logic [7:0]            w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic                  w_err_q, w_err_d;
    logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;

    r_state_e              r_state_q, r_state_d;
    logic [AXI_ID_WIDTH-1:0] r_id_q, r_id_d;
    logic [IDX_W-1:0]      r_idx_q, r_idx_d;
    logic [7:0]            r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic                  r_err_q, r_err_d;
    logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [1:0]            rresp_q, rresp_d;

    logic                  mem_we, mem_re;
    logic [IDX_W-1:0]      mem_raddr;
    logic [AXI_DATA_WIDTH-1:0] mem_rdata;
    logic                  unused_addr;

    // Write channel: AW latch, beat counting with wlast cross-check, then B.
    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        bresp_d   = bresp_q;
        mem_we    = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                if (s_axi_awvalid && awready_q) begin
                    w_state_d = W_DATA;
                    w_id_d    = s_axi_awid;
                    w_idx_d   = s_axi_awaddr[BEAT_LSB +: IDX_W];
                    w_len_d   = s_axi_awlen;
                    w_cnt_d   = 8'd0;
                    w_err_d   = bad_req(s_axi_awsize, s_axi_awburst);
                end
            end
            W_DATA: begin
                if (s_axi_wvalid && wready_q) begin
                    mem_we  = !w_err_q;
                    w_idx_d = w_idx_q + IDX_W'(1);
                    w_cnt_d = w_cnt_q + 8'd1;
                    // wlast must coincide exactly with beat awlen+1; once flagged, later beats are dropped.
                    if (s_axi_wlast != (w_cnt_q == w_len_q)) begin
                        w_err_d = 1'b1;
                    end
                    if (s_axi_wlast) begin
                        w_state_d = W_RESP;
                        bresp_d   = w_err_d ? RESP_SLVERR : RESP_OKAY;
                    end
                end
            end
            W_RESP: begin
                if (bvalid_q && s_axi_bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
    end

    // Read channel: prefetch the next beat on every non-final handshake so R streams back-to-back.
    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_err_d   = r_err_q;
        rresp_d   = rresp_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        mem_re    = 1'b0;
        mem_raddr = r_idx_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (s_axi_arvalid && arready_q) begin
                    r_state_d = R_DATA;
                    r_id_d    = s_axi_arid;
                    r_len_d   = s_axi_arlen;
                    r_cnt_d   = 8'd0;
                    r_err_d   = bad_req(s_axi_arsize, s_axi_arburst);
                    rresp_d   = r_err_d ? RESP_SLVERR : RESP_OKAY;
                    mem_re    = 1'b1;
                    mem_raddr = s_axi_araddr[BEAT_LSB +: IDX_W];
                    r_idx_d   = mem_raddr + IDX_W'(1);
                    rvalid_d  = 1'b1;
                    rlast_d   = (s_axi_arlen == 8'd0);
                end
            end
            R_DATA: begin
                if (rvalid_q && s_axi_rready) begin
                    if (rlast_q) begin
                        r_state_d = R_IDLE;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                    end else begin
                        mem_re  = 1'b1;
                        r_idx_d = r_idx_q + IDX_W'(1);
                        r_cnt_d = r_cnt_q + 8'd1;
                        rlast_d = ((r_cnt_q + 8'd1) == r_len_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_err_q   <= 1'b0;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_err_q   <= r_err_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
        end
    end

    axi_mem_bank #(
        .DATA_WIDTH (AXI_DATA_WIDTH),
        .ADDR_WIDTH (MEM_ADDR_WIDTH)
    ) u_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .waddr (w_idx_q),
        .wdata (s_axi_wdata),
        .wstrb (s_axi_wstrb),
        .re    (mem_re),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    // Addresses alias modulo the RAM size; sub-beat offset bits carry no meaning.
    assign unused_addr = ^{s_axi_awaddr[AXI_ADDR_WIDTH-1:BEAT_LSB+IDX_W], s_axi_awaddr[BEAT_LSB-1:0],
                           s_axi_araddr[AXI_ADDR_WIDTH-1:BEAT_LSB+IDX_W], s_axi_araddr[BEAT_LSB-1:0]};

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bid     = w_id_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rid     = r_id_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = r_err_q ? '0 : mem_rdata;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Randomized bench for axi_mem_responder against a transaction-level memory model.
module tb_axi_mem_responder;
    import herv_axi_pkg::*;

    localparam int DW    = 512;
    localparam int IW    = 12;
    localparam int DEPTH = 1024;
    localparam int WAIT  = 200;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [IW-1:0] awid, bid, arid, rid;
    logic [63:0]   awaddr, araddr;
    logic [7:0]    awlen, arlen;
    logic [2:0]    awsize, arsize;
    logic [1:0]    awburst, arburst, bresp, rresp;
    logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rlast, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [63:0]   wstrb;

    axi_mem_responder dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
        .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
        .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    typedef struct { logic [IW-1:0] id; logic [1:0] resp; logic [DW-1:0] data; logic last; } rbeat_t;
    typedef struct { logic [IW-1:0] id; logic [1:0] resp; } bexp_t;

    logic [DW-1:0] mdl [DEPTH];
    rbeat_t rq[$];
    bexp_t  bq[$];
    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;
    bit  prev_wlast_hs, prev_ar_hs, prev_r_more, prev_r_last;

    function automatic void check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait expired at %0t", name, $time);
    endfunction

    function automatic logic [DW-1:0] pat(input logic [31:0] base, input int k);
        logic [31:0] w;
        w = base + 32'(k);
        return {16{w}};
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    function automatic int beat_idx(input logic [63:0] addr);
        return int'((addr >> 6) % 64'(DEPTH));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle compare against expected B/R queues plus handshake-timing rules.
    always @(negedge clk) begin
        if (rst || !mon_en) begin
            prev_wlast_hs = 1'b0; prev_ar_hs = 1'b0; prev_r_more = 1'b0; prev_r_last = 1'b0;
        end else begin
            if (prev_wlast_hs) check("b_latency", DW'(bvalid), DW'(1));
            if (prev_ar_hs || prev_r_more) check("rvalid_no_bubble", DW'(rvalid), DW'(1));
            if (prev_r_last) check("rvalid_drop", DW'(rvalid), DW'(0));
            if (bvalid) begin
                check("b_expected", DW'(bq.size() != 0), DW'(1));
                if (bq.size() != 0) begin
                    check("bid", DW'(bid), DW'(bq[0].id));
                    check("bresp", DW'(bresp), DW'(bq[0].resp));
                    if (bready) void'(bq.pop_front());
                end
            end
            if (rvalid) begin
                check("r_expected", DW'(rq.size() != 0), DW'(1));
                if (rq.size() != 0) begin
                    check("rid", DW'(rid), DW'(rq[0].id));
                    check("rresp", DW'(rresp), DW'(rq[0].resp));
                    check("rdata", rdata, rq[0].data);
                    check("rlast", DW'(rlast), DW'(rq[0].last));
                    if (rready) void'(rq.pop_front());
                end
            end
            prev_wlast_hs = wvalid && wready && wlast;
            prev_ar_hs    = arvalid && arready;
            prev_r_more   = rvalid && rready && !rlast;
            prev_r_last   = rvalid && rready && rlast;
        end
    end

    task automatic do_write(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input int nbeats, input bit rdata_mode,
                            input logic [31:0] base, input logic [63:0] strb, input bit rstrb,
                            input int bdelay);
        logic [IW-1:0] wid;
        logic [DW-1:0] d;
        logic [63:0]   s;
        bit err;
        int idx, n;
        wid = IW'($urandom);
        err = (size != 3'd6) || (burst != 2'b01);
        idx = beat_idx(addr);
        bq.push_back('{id: wid, resp: (err || nbeats != int'(len) + 1) ? RESP_SLVERR : RESP_OKAY});
        awid = wid; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (!awready && n < WAIT) begin tick(); n++; end
        if (n >= WAIT) timeout("awready_wait");
        tick();
        awvalid = 1'b0;
        for (int k = 0; k < nbeats; k++) begin
            d = rdata_mode ? rnd_data() : pat(base, k);
            s = rstrb ? {32'($urandom), 32'($urandom)} : strb;
            wdata = d; wstrb = s; wlast = (k == nbeats - 1); wvalid = 1'b1;
            n = 0;
            while (!wready && n < WAIT) begin tick(); n++; end
            if (n >= WAIT) timeout("wready_wait");
            tick();
            // Beats inside awlen+1 of a well-formed request land in memory; extras are dropped.
            if (!err && k <= int'(len)) begin
                for (int b = 0; b < 64; b++)
                    if (s[b]) mdl[(idx + k) % DEPTH][8*b +: 8] = d[8*b +: 8];
            end
        end
        wvalid = 1'b0; wlast = 1'b0;
        n = 0;
        while (n < WAIT) begin
            bready = (n >= bdelay);
            if (bvalid && bready) break;
            tick(); n++;
        end
        if (n >= WAIT) timeout("bvalid_wait");
        else tick();
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input int rmode);
        logic [IW-1:0] id;
        bit err;
        int idx, n, got, cyc;
        id  = IW'($urandom);
        err = (size != 3'd6) || (burst != 2'b01);
        idx = beat_idx(addr);
        for (int k = 0; k <= int'(len); k++)
            rq.push_back('{id: id, resp: err ? RESP_SLVERR : RESP_OKAY,
                           data: err ? '0 : mdl[(idx + k) % DEPTH], last: (k == int'(len))});
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        n = 0;
        while (!arready && n < WAIT) begin tick(); n++; end
        if (n >= WAIT) timeout("arready_wait");
        tick();
        arvalid = 1'b0;
        got = 0; cyc = 0;
        while (got <= int'(len) && cyc < 4000) begin
            case (rmode)
                0:       rready = 1'b1;
                1:       rready = (cyc % 3 == 0);
                default: rready = 1'($urandom_range(0, 1));
            endcase
            if (rvalid && rready) got++;
            tick(); cyc++;
        end
        rready = 1'b0;
        if (got <= int'(len)) timeout("r_beats");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] exp_word;
        rst = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
        tick(); tick(); tick();
        check("rst_awready", DW'(awready), DW'(1));
        check("rst_arready", DW'(arready), DW'(1));
        check("rst_wready", DW'(wready), DW'(0));
        check("rst_bvalid", DW'(bvalid), DW'(0));
        check("rst_rvalid", DW'(rvalid), DW'(0));
        check("rst_rlast", DW'(rlast), DW'(0));
        check("rst_bresp_rresp", DW'({bresp, rresp}), DW'(0));
        check("rst_bid_rid", DW'({bid, rid}), DW'(0));
        check("rst_rdata", rdata, '0);
        rst = 1'b0;
        tick();
        mon_en = 1'b1;

        // Fill RAM so every later read has a known model value.
        for (int q = 0; q < 4; q++)
            do_write(64'(q * 256 * 64), 8'd255, 3'd6, 2'd1, 256, 1'b1, 32'd0, '1, 1'b0, 0);

        // Basic burst write/readback.
        do_write(64'h40, 8'd3, 3'd6, 2'd1, 4, 1'b0, 32'hA000_0000, '1, 1'b0, 0);
        check("model_pin_idx1", mdl[1], {16{32'hA000_0000}});
        check("model_pin_idx4", mdl[4], {16{32'hA000_0003}});
        do_read(64'h40, 8'd3, 3'd6, 2'd1, 0);

        // Partial strobe merge.
        do_write(64'h2000, 8'd0, 3'd6, 2'd1, 1, 1'b0, 32'h1111_0000, '1, 1'b0, 0);
        do_write(64'h2000, 8'd0, 3'd6, 2'd1, 1, 1'b0, 32'h2222_0000, 64'hFF, 1'b0, 2);
        exp_word = {{14{32'h1111_0000}}, {2{32'h2222_0000}}};
        check("model_pin_strobe", mdl[128], exp_word);
        do_read(64'h2000, 8'd0, 3'd6, 2'd1, 0);

        // Stalled reader.
        do_read(64'h40, 8'd7, 3'd6, 2'd1, 1);

        // Malformed requests.
        do_write(64'h40, 8'd1, 3'd5, 2'd1, 2, 1'b1, 32'd0, '1, 1'b0, 0);
        do_write(64'h40, 8'd1, 3'd6, 2'd0, 2, 1'b1, 32'd0, '1, 1'b0, 1);
        check("model_pin_err_unchanged", mdl[1], {16{32'hA000_0000}});
        do_read(64'h40, 8'd1, 3'd6, 2'd1, 0);
        do_read(64'h40, 8'd3, 3'd6, 2'd2, 2);

        // wlast early and late.
        do_write(64'h300, 8'd3, 3'd6, 2'd1, 2, 1'b1, 32'd0, '1, 1'b0, 0);
        do_write(64'h400, 8'd3, 3'd6, 2'd1, 6, 1'b1, 32'd0, '1, 1'b0, 0);
        do_read(64'h300, 8'd15, 3'd6, 2'd1, 0);

        // Index wrap and upper-bit aliasing.
        do_write(64'hFFC0, 8'd1, 3'd6, 2'd1, 2, 1'b0, 32'hC0DE_0000, '1, 1'b0, 0);
        check("model_pin_wrap0", mdl[0], {16{32'hC0DE_0001}});
        do_read(64'hFFC0, 8'd1, 3'd6, 2'd1, 0);
        do_read(64'h1_0000, 8'd0, 3'd6, 2'd1, 0);

        // Same-cycle read and write of index 5 returns the pre-write data.
        fork
            do_write(64'h140, 8'd0, 3'd6, 2'd1, 1, 1'b0, 32'h5555_0000, '1, 1'b0, 0);
            begin tick(); do_read(64'h140, 8'd0, 3'd6, 2'd1, 0); end
        join
        do_read(64'h140, 8'd0, 3'd6, 2'd1, 0);

        // Reset in the middle of a read burst.
        mon_en = 1'b0;
        arid = 12'h123; araddr = 64'h40; arlen = 8'd15; arsize = 3'd6; arburst = 2'd1;
        arvalid = 1'b1; rready = 1'b1;
        tick();
        arvalid = 1'b0;
        tick(); tick();
        check("mid_burst_active", DW'(rvalid), DW'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0; rready = 1'b0;
        check("mid_rst_rvalid", DW'(rvalid), DW'(0));
        check("mid_rst_arready", DW'(arready), DW'(1));
        check("mid_rst_rlast", DW'(rlast), DW'(0));
        check("mid_rst_rdata", rdata, '0);
        tick();
        mon_en = 1'b1;
        do_read(64'h40, 8'd3, 3'd6, 2'd1, 2);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            logic [63:0] a;
            logic [7:0]  l;
            int nb;
            a = {32'($urandom), 32'($urandom)};
            l = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) begin
                case ($urandom_range(0, 9))
                    0:       nb = (l > 0) ? int'(l) : 1;
                    1:       nb = int'(l) + 2;
                    default: nb = int'(l) + 1;
                endcase
                do_write(a, l, ($urandom_range(0, 9) == 0) ? 3'd5 : 3'd6,
                         ($urandom_range(0, 9) == 0) ? 2'd0 : 2'd1, nb, 1'b1, 32'd0, '1,
                         1'($urandom_range(0, 1)), $urandom_range(0, 3));
            end else begin
                do_read(a, l, 3'd6, ($urandom_range(0, 9) == 0) ? 2'd2 : 2'd1, $urandom_range(0, 2));
            end
        end

        tick(); tick();
        check("r_queue_drained", DW'(rq.size()), DW'(0));
        check("b_queue_drained", DW'(bq.size()), DW'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_mem_responder.md
Name: axi_mem_responder

Overview:
- AXI4 slave responder (subordinate) for the 512-bit AXI data master port of the FPGA top.
- Backs AW/W/B and AR/R bursts with an on-chip byte-enabled RAM.
- Serves as the simulation/emulation memory model and as a loopback target for DMA bring-up without external DDR.
- Supports one outstanding write burst and one outstanding read burst; the two channels run independently and concurrently.

Parameters:
- AXI_ADDR_WIDTH, 64, address width.
- AXI_DATA_WIDTH, 512, data width; one beat = 64 bytes.
- AXI_ID_WIDTH, 12, ID width.
- MEM_ADDR_WIDTH, 10, log2 of RAM depth in beats (default 1024 beats = 64 KiB).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- s_axi_awid  in  12  write ID
- s_axi_awaddr  in  64  write byte address
- s_axi_awlen  in  8  beats-1
- s_axi_awsize  in  3  must be 6
- s_axi_awburst  in  2  must be INCR (1)
- s_axi_awvalid  in  1 / s_axi_awready  out  1  AW handshake
- s_axi_wdata  in  512 / s_axi_wstrb  in  64 / s_axi_wlast  in  1  write beat
- s_axi_wvalid  in  1 / s_axi_wready  out  1  W handshake
- s_axi_bid  out  12 / s_axi_bresp  out  2  write response
- s_axi_bvalid  out  1 / s_axi_bready  in  1  B handshake
- s_axi_arid  in  12 / s_axi_araddr  in  64 / s_axi_arlen  in  8 / s_axi_arsize  in  3 / s_axi_arburst  in  2  read request
- s_axi_arvalid  in  1 / s_axi_arready  out  1  AR handshake
- s_axi_rid  out  12 / s_axi_rdata  out  512 / s_axi_rresp  out  2 / s_axi_rlast  out  1  read beat
- s_axi_rvalid  out  1 / s_axi_rready  in  1  R handshake

Behaviour:
- Clocking and reset: single clock domain `clk`. Reset is synchronous and active-high on `rst`.
- Reset values:
  - awready=1, arready=1.
  - wready=0, bvalid=0, rvalid=0, rlast=0.
  - bresp=0, rresp=0, bid=0, rid=0, rdata=0.
  - RAM contents are not reset.
- Addressing:
  - Beat index = addr[6 +: MEM_ADDR_WIDTH]. Low 6 bits are ignored.
  - Upper bits are ignored, so addresses alias modulo the RAM size.
  - Index increments by 1 per beat and wraps from 2^MEM_ADDR_WIDTH-1 to 0.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1. On AW handshake, latch id, index and err = (awsize!=6 || awburst!=1), clear beat count, go to W_DATA. awready drops the next cycle.
  - W_DATA: wready=1.
    - Each W handshake writes wdata under the wstrb byte enables, unless err is set. Index and count increment.
    - A W handshake with wlast=1 goes to W_RESP.
    - Beat-count mismatch sets err: wlast on a beat other than awlen+1, or beat awlen+1 arriving without wlast.
    - Beats beyond awlen+1 are discarded (not written); the burst still ends only on wlast.
  - W_RESP: bvalid=1, bid=latched id, bresp = err ? 2'b10 : 2'b00. Hold until bready, then return to W_IDLE.
  - Latency: bvalid is asserted the cycle after the wlast handshake. Throughput is one beat per cycle with wvalid held high.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready=1. On AR handshake, latch id, len, index and err (same rule as write), and issue a RAM read of the index. rvalid rises the next cycle. Go to R_DATA.
  - R_DATA:
    - rdata = RAM output, or 0 if err. rresp = err ? 2'b10 : 2'b00. rid = latched id.
    - rlast=1 on beat arlen+1.
    - On an R handshake that is not the last beat, the next index is read in the same cycle, so rvalid stays high with no bubbles.
    - With rready=0, rvalid, rdata and rlast are held stable (the RAM output register is not re-enabled).
    - On the rlast handshake: rvalid=0 the next cycle, return to R_IDLE.
- RAM: dual-port, write-first disabled (read-first). A read and a write to the same index in the same cycle return the old data.
- arlen=0 / awlen=0: single-beat bursts. rlast and wlast apply to the first beat.
- Reset asserted mid-burst: both FSMs return to idle immediately and outputs take their reset values. RAM contents are retained.

Decomposition:
- Package herv_axi_pkg holds:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - BURST_INCR=2'b01, SIZE_64B=3'd6
  - Write FSM and read FSM state enums.
- Sub-module axi_mem_bank: simple dual-port RAM, 64 byte-enables, synchronous read with read enable, read-first.

Test Plan:
- Write awaddr=0x40, awlen=3 with pattern data and full strobes, then read back the same address and length -> bresp=0 one cycle after wlast; four R beats matching the pattern, rlast on the 4th, rid=arid.
- Write with wstrb=0x0000_0000_0000_00FF over a known word -> only bytes 0-7 change; read returns merged data.
- Read arlen=7 with rready toggling 1,0,0,1... -> rdata/rlast stable while stalled; 8 beats in order; no dropped or duplicated beat.
- awsize=5 (or awburst=0) -> bresp=2'b10 and memory unchanged. arburst=2 -> rresp=2'b10 with rdata=0 on every beat.
- awlen=3 with wlast on beat 2 -> bresp=2'b10, burst ends after beat 2.
- Concurrent read and write to index 5, plus a wrap from index 1023 to index 0 (awaddr=0xFFC0, awlen=1) -> beats land at indices 1023 and 0; a same-cycle read of index 5 returns the old value.
- Reset asserted mid-read-burst -> next cycle rvalid=0, arready=1, and a fresh AR completes normally.
